// File: rtl/lcd_display_scheduler.sv
// rtl/lcd_display_scheduler.sv - rotates dosage-table entries onto the LCD with alarm pre-emption
module lcd_display_scheduler #(
    parameter int NUM_PATIENTS = 4,
    parameter int DWELL_TICKS  = 800,
    parameter int ALARM_TICKS  = 1200
) (
    input  logic        CLK_400Hz,
    input  logic        reset,
    input  logic        enable,
    output logic        tbl_rd_en,
    output logic [3:0]  tbl_addr,
    input  logic [11:0] tbl_rd_data,
    input  logic        alarm_req,
    input  logic [3:0]  alarm_pid,
    output logic        alarm_ack,
    output logic        alarm_active,
    output logic [3:0]  patientID,
    output logic [11:0] pill12And3Duration,
    output logic        disp_upd
);

    localparam int MAX_TICKS = (DWELL_TICKS > ALARM_TICKS) ? DWELL_TICKS : ALARM_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TICKS - 1);
    localparam logic [3:0]       LAST_IDX   = 4'(NUM_PATIENTS - 1);
    localparam logic [4:0]       NUM_PAT5   = 5'(NUM_PATIENTS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAP,
        SHOW,
        ALARM_FETCH,
        ALARM_CAP,
        ALARM_SHOW
    } state_t;

    state_t           state;
    logic [3:0]       cur_idx;
    logic [3:0]       alarm_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       next_idx;

    always_comb begin
        next_idx = 4'd0;
        if (cur_idx != LAST_IDX) begin
            next_idx = cur_idx + 4'd1;
        end
    end

    // Outputs are registered alongside the state: tbl_rd_en/tbl_addr are
    // loaded on entry to a fetch state so the table sees them during it.
    always_ff @(posedge CLK_400Hz) begin
        if (reset) begin
            state              <= IDLE;
            cur_idx            <= 4'd0;
            alarm_idx          <= 4'd0;
            cnt                <= '0;
            tbl_rd_en          <= 1'b0;
            tbl_addr           <= 4'd0;
            alarm_ack          <= 1'b0;
            alarm_active       <= 1'b0;
            patientID          <= 4'd0;
            pill12And3Duration <= 12'd0;
            disp_upd           <= 1'b0;
        end else begin
            tbl_rd_en <= 1'b0;
            tbl_addr  <= 4'd0;
            alarm_ack <= 1'b0;
            disp_upd  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= FETCH;
                        tbl_rd_en <= 1'b1;
                        tbl_addr  <= cur_idx;
                    end
                end
                FETCH: state <= CAP;
                CAP: begin
                    patientID          <= cur_idx;
                    pill12And3Duration <= tbl_rd_data;
                    disp_upd           <= 1'b1;
                    cnt                <= DWELL_LOAD;
                    state              <= SHOW;
                end
                SHOW: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (alarm_req && ({1'b0, alarm_pid} < NUM_PAT5)) begin
                        alarm_ack    <= 1'b1;
                        alarm_idx    <= alarm_pid;
                        alarm_active <= 1'b1;
                        tbl_rd_en    <= 1'b1;
                        tbl_addr     <= alarm_pid;
                        state        <= ALARM_FETCH;
                    end else begin
                        // An out-of-range alarm is acknowledged but the rotation carries on.
                        if (alarm_req) begin
                            alarm_ack <= 1'b1;
                            alarm_idx <= alarm_pid;
                        end
                        if (cnt == '0) begin
                            cur_idx   <= next_idx;
                            tbl_rd_en <= 1'b1;
                            tbl_addr  <= next_idx;
                            state     <= FETCH;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ALARM_FETCH: state <= ALARM_CAP;
                ALARM_CAP: begin
                    patientID          <= alarm_idx;
                    pill12And3Duration <= tbl_rd_data;
                    disp_upd           <= 1'b1;
                    cnt                <= ALARM_LOAD;
                    state              <= ALARM_SHOW;
                end
                ALARM_SHOW: begin
                    if (cnt == '0) begin
                        alarm_active <= 1'b0;
                        tbl_rd_en    <= 1'b1;
                        tbl_addr     <= cur_idx;
                        state        <= FETCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
